// File: rtl/exe_stage.sv
// Execute stage: ALU, branch/jump resolution and the EX/MEM register.
// Also counts how many PC redirects have been taken.
module exe_stage (
    input  logic         clk,
    input  logic         clr,
    input  logic [131:0] id_ex,
    input  logic         stall,
    input  logic         flush,
    output logic [71:0]  out,
    output logic         redirect,
    output logic [31:0]  target,
    output logic         flush_up,
    output logic [15:0]  taken_cnt
);

    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch_eq;
    logic        jump;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  aluc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] pc4;

    assign reg_write  = id_ex[0];
    assign mem_to_reg = id_ex[1];
    assign mem_write  = id_ex[2];
    assign branch_eq  = id_ex[3];
    assign jump       = id_ex[4];
    assign alu_src    = id_ex[5];
    assign reg_dst    = id_ex[6];
    assign aluc       = id_ex[9:7];
    assign rt         = id_ex[14:10];
    assign rd         = id_ex[19:15];
    assign imm        = id_ex[35:20];
    assign qa         = id_ex[67:36];
    assign qb         = id_ex[99:68];
    assign pc4        = id_ex[131:100];

    logic [31:0] sext;
    logic [31:0] opb;
    logic [31:0] alu_res;
    logic [4:0]  wreg;
    logic        zero;
    logic        take;

    assign sext = {{16{imm[15]}}, imm};
    assign opb  = alu_src ? sext : qb;
    assign wreg = reg_dst ? rd : rt;

    // Branch compare always uses the register operands, never the immediate.
    assign zero = (qa == qb);
    assign take = jump | (branch_eq & zero);

    assign redirect = take & ~stall & ~clr;
    assign flush_up = redirect;
    assign target   = jump ? {pc4[31:18], imm, 2'b00}
                           : pc4 + {sext[29:0], 2'b00};

    // ALU result selected by the 3-bit operation code.
    always_comb begin
        alu_res = 32'h0;
        unique case (aluc)
            3'b000: alu_res = qa + opb;
            3'b001: alu_res = qa - opb;
            3'b010: alu_res = qa & opb;
            3'b011: alu_res = qa | opb;
            3'b100: alu_res = qa ^ opb;
            3'b101: alu_res = {31'h0, $signed(qa) < $signed(opb)};
            3'b110: alu_res = {imm, 16'h0};
            3'b111: alu_res = ~(qa | opb);
        endcase
    end

    // EX/MEM register: reset, then hold on stall, then bubble the control bits on flush.
    always_ff @(posedge clk) begin
        if (clr) begin
            out <= 72'h0;
        end else if (!stall) begin
            out[71:3] <= {qb, alu_res, wreg};
            if (flush) begin
                out[2:0] <= 3'b000;
            end else begin
                out[2:0] <= {mem_write, mem_to_reg, reg_write};
            end
        end
    end

    // Saturating count of redirects actually issued.
    always_ff @(posedge clk) begin
        if (clr) begin
            taken_cnt <= 16'h0;
        end else if (redirect && taken_cnt != 16'hFFFF) begin
            taken_cnt <= taken_cnt + 16'h1;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table, scoreboard queue for the
// registered bundle, and hand sequences for stall, saturation and reset.
module tb_exe_stage;

    logic         clk;
    logic         clr;
    logic [131:0] id_ex;
    logic         stall;
    logic         flush;
    logic [71:0]  out;
    logic         redirect;
    logic [31:0]  target;
    logic         flush_up;
    logic [15:0]  taken_cnt;

    exe_stage dut (
        .clk       (clk),
        .clr       (clr),
        .id_ex     (id_ex),
        .stall     (stall),
        .flush     (flush),
        .out       (out),
        .redirect  (redirect),
        .target    (target),
        .flush_up  (flush_up),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  aluc;
        logic        alusrc;
        logic        regdst;
        logic [4:0]  ctl;
        logic        fl;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] pc4;
        logic [31:0] ealu;
        logic [4:0]  ewreg;
        logic        eredir;
        logic [31:0] etgt;
    } vec_t;

    vec_t        vecs[$];
    logic [71:0] sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt;
    logic [71:0] last_exp;

    function automatic vec_t mk(
        input logic [2:0] aluc, input logic alusrc, input logic regdst,
        input logic [4:0] ctl, input logic fl,
        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
        input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] pc4,
        input logic [31:0] ealu, input logic [4:0] ewreg,
        input logic eredir, input logic [31:0] etgt);
        vec_t v;
        v.aluc = aluc; v.alusrc = alusrc; v.regdst = regdst;
        v.ctl = ctl; v.fl = fl; v.rt = rt; v.rd = rd; v.imm = imm;
        v.qa = qa; v.qb = qb; v.pc4 = pc4; v.ealu = ealu;
        v.ewreg = ewreg; v.eredir = eredir; v.etgt = etgt;
        return v;
    endfunction

    // ctl = {jump, branch_eq, mem_write, mem_to_reg, reg_write}
    function automatic logic [131:0] pack(input vec_t v);
        return {v.pc4, v.qb, v.qa, v.imm, v.rd, v.rt, v.aluc,
                v.regdst, v.alusrc, v.ctl[4], v.ctl[3],
                v.ctl[2], v.ctl[1], v.ctl[0]};
    endfunction

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [71:0] e;
        int n;

        vecs.push_back(mk(1, 0, 1, 5'b00001, 0, 2, 7, 16'h0, 5, 3, 0, 2, 7, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5'b00011, 0, 5, 9, 16'hFFFF, 10, 32'h77, 0, 9, 5, 0, 0));
        vecs.push_back(mk(2, 0, 1, 5'b00001, 0, 1, 3, 16'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 3, 0, 0));
        vecs.push_back(mk(3, 0, 0, 5'b00001, 0, 4, 8, 16'h0, 32'h1200, 32'h34, 0, 32'h1234, 4, 0, 0));
        vecs.push_back(mk(4, 0, 1, 5'b00101, 0, 6, 31, 16'h0, 32'hFFFF0000, 32'h0F0F0F0F, 0, 32'hF0F00F0F, 31, 0, 0));
        vecs.push_back(mk(5, 0, 0, 5'b00001, 0, 10, 0, 16'h0, 32'hFFFFFFFF, 1, 0, 1, 10, 0, 0));
        vecs.push_back(mk(5, 0, 0, 5'b00001, 0, 11, 0, 16'h0, 1, 32'hFFFFFFFF, 0, 0, 11, 0, 0));
        vecs.push_back(mk(6, 1, 0, 5'b00001, 0, 12, 0, 16'hABCD, 0, 0, 0, 32'hABCD0000, 12, 0, 0));
        vecs.push_back(mk(7, 0, 0, 5'b00001, 0, 13, 0, 16'h0, 32'h0F0F0000, 32'hFF, 0, 32'hF0F0FF00, 13, 0, 0));
        vecs.push_back(mk(1, 0, 0, 5'b00011, 0, 14, 0, 16'h0, 0, 1, 0, 32'hFFFFFFFF, 14, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5'b01000, 0, 0, 0, 16'hFFFE, 9, 9, 32'h100, 18, 0, 1, 32'hF8));
        vecs.push_back(mk(0, 0, 0, 5'b01000, 0, 0, 0, 16'h0, 1, 2, 32'h100, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5'b10000, 0, 0, 0, 16'h1234, 0, 0, 32'hF0000004, 0, 0, 1, 32'hF00048D0));
        vecs.push_back(mk(0, 0, 0, 5'b11000, 0, 0, 0, 16'h0010, 5, 5, 32'h200, 10, 0, 1, 32'h40));
        vecs.push_back(mk(0, 1, 0, 5'b01000, 0, 0, 0, 16'h4, 3, 3, 32'h1000, 7, 0, 1, 32'h1010));
        vecs.push_back(mk(0, 0, 0, 5'b00101, 1, 0, 0, 16'h0, 4, 4, 0, 8, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5'b01001, 1, 0, 0, 16'h1, 2, 2, 32'h40, 4, 0, 1, 32'h44));

        // reset with a jump presented: redirect must stay low
        v = mk(0, 0, 0, 5'b10001, 0, 0, 0, 16'h1, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b1; stall = 1'b0; flush = 1'b0; id_ex = pack(v);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, 72'h0);
        chk("reset_cnt", {56'h0, taken_cnt}, 72'h0);
        chk("reset_redirect", {71'h0, redirect}, 72'h0);
        chk("reset_flush_up", {71'h0, flush_up}, 72'h0);
        exp_cnt = 16'h0;
        last_exp = 72'h0;

        @(negedge clk);
        clr = 1'b0;
        foreach (vecs[i]) begin
            v = vecs[i];
            id_ex = pack(v);
            flush = v.fl;
            stall = 1'b0;
            #1;
            chk($sformatf("redirect_%0d", i), {71'h0, redirect}, {71'h0, v.eredir});
            chk($sformatf("flush_up_%0d", i), {71'h0, flush_up}, {71'h0, v.eredir});
            if (v.eredir)
                chk($sformatf("target_%0d", i), {40'h0, target}, {40'h0, v.etgt});
            e = {v.qb, v.ealu, v.ewreg, v.fl ? 3'b000 : v.ctl[2:0]};
            sb.push_back(e);
            if (v.eredir && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_empty", 72'h1, 72'h0);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                chk($sformatf("out_%0d", i), out, e);
            end
            chk($sformatf("cnt_%0d", i), {56'h0, taken_cnt}, {56'h0, exp_cnt});
            @(negedge clk);
        end

        // stall beats flush and blocks a jump redirect
        v = mk(0, 0, 1, 5'b10111, 0, 3, 4, 16'h5, 32'h11, 32'h22, 0, 0, 0, 0, 0);
        id_ex = pack(v); stall = 1'b1; flush = 1'b1;
        #1;
        chk("stall_redirect", {71'h0, redirect}, 72'h0);
        chk("stall_flush_up", {71'h0, flush_up}, 72'h0);
        @(posedge clk);
        #1;
        chk("stall_out", out, last_exp);
        chk("stall_cnt", {56'h0, taken_cnt}, {56'h0, exp_cnt});

        // run jumps until the counter saturates
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        n = 16'hFFFF - exp_cnt;
        repeat (n) @(negedge clk);
        exp_cnt = 16'hFFFF;
        chk("sat_reach", {56'h0, taken_cnt}, {56'h0, exp_cnt});
        @(negedge clk);
        chk("sat_hold", {56'h0, taken_cnt}, 72'hFFFF);
        chk("sat_out", out, {32'h22, 32'h33, 5'd4, 3'b111});

        // reset overrides stall and flush
        clr = 1'b1; stall = 1'b1; flush = 1'b1;
        #1;
        chk("clr_redirect", {71'h0, redirect}, 72'h0);
        @(posedge clk);
        #1;
        chk("clr_out", out, 72'h0);
        chk("clr_cnt", {56'h0, taken_cnt}, 72'h0);

        // first edge after reset captures normally
        @(negedge clk);
        clr = 1'b0; stall = 1'b0; flush = 1'b0;
        v = vecs[0];
        id_ex = pack(v);
        sb.push_back({v.qb, v.ealu, v.ewreg, v.ctl[2:0]});
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk("sb_empty2", 72'h1, 72'h0);
        else chk("resume_out", out, sb.pop_front());
        chk("resume_cnt", {56'h0, taken_cnt}, 72'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
